// File: rtl/demux2_buf.sv
// Registered 1-to-2 stream demultiplexer: each accepted word is steered by sel
// into one of two independent 2-entry skid FIFOs, each with its own pop counter.
module demux2_buf #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  logic                       acc;
  logic [1:0]                 push;
  logic [1:0]                 rdy;
  logic [1:0]                 vld;
  logic [1:0]                 spc;
  logic [1:0][WIDTH-1:0]      dout;
  logic [1:0][CNT_W-1:0]      cnt;

  assign acc  = in_valid && in_ready;
  assign push = {acc & sel, acc & ~sel};
  assign rdy  = {out1_ready, out0_ready};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    occ_t             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             space_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop;

    assign pop = (occ_q != EMPTY) && rdy[g];

    // Shift scheme: head_q is always the word presented to the consumer.
    always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case (occ_q)
        EMPTY: begin
          if (push[g]) begin
            occ_d  = ONE;
            head_d = in_data;
          end
        end
        ONE: begin
          if (push[g] && pop) begin
            head_d = in_data;
          end else if (push[g]) begin
            occ_d  = FULL;
            tail_d = in_data;
          end else if (pop) begin
            occ_d  = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            occ_d  = ONE;
            head_d = tail_q;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end

    // space_q mirrors occ_d so in_ready is a pure mux of flops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        occ_q   <= EMPTY;
        head_q  <= '0;
        tail_q  <= '0;
        space_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        occ_q   <= occ_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
        space_q <= (occ_d != FULL);
        if (pop) cnt_q <= cnt_q + 1'b1;
      end
    end

    assign vld[g]  = (occ_q != EMPTY);
    assign spc[g]  = space_q;
    assign dout[g] = head_q;
    assign cnt[g]  = cnt_q;
  end

  assign in_ready   = sel ? spc[1] : spc[0];
  assign out0_valid = vld[0];
  assign out1_valid = vld[1];
  assign out0_data  = dout[0];
  assign out1_data  = dout[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux2_buf.sv
// Scoreboard bench for demux2_buf: the driver queues expected words on
// acceptance, a negedge monitor pops and compares on every output handshake.
module tb_demux2_buf;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int nchk = 0;
  int nerr = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [CNT_W-1:0] exp_cnt0 = '0;
  logic [CNT_W-1:0] exp_cnt1 = '0;

  demux2_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sel        (sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Drive one word and hold it until accepted; queue it on acceptance.
  task automatic send(input logic [WIDTH-1:0] d, input logic s);
    int  waitc = 0;
    bit  done  = 0;
    in_data  = d;
    sel      = s;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
        done = 1;
      end else if (++waitc > 50) begin
        fail_event("send_timeout");
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake must match the head of the matching queue.
  always @(negedge clk) begin
    if (out0_valid && out0_ready) begin
      if (q0.size() == 0) fail_event("out0_spurious");
      else check("out0_data", {24'd0, out0_data}, {24'd0, q0.pop_front()});
      exp_cnt0 = exp_cnt0 + 1'b1;
    end
    if (out1_valid && out1_ready) begin
      if (q1.size() == 0) fail_event("out1_spurious");
      else check("out1_data", {24'd0, out1_data}, {24'd0, q1.pop_front()});
      exp_cnt1 = exp_cnt1 + 1'b1;
    end
  end

  initial begin
    in_valid   = 1'b0;
    in_data    = '0;
    sel        = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;

    // 1: reset holds everything idle even with in_valid high
    in_valid = 1'b1;
    in_data  = 8'h77;
    idle(2);
    check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("rst_out0_data", {24'd0, out0_data}, 32'd0);
    check("rst_cnt0", {28'd0, cnt0}, 32'd0);
    check("rst_cnt1", {28'd0, cnt1}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(3);
    check("post_rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("post_rst_out1_valid", {31'd0, out1_valid}, 32'd0);

    // 2: streaming to out0
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    idle(3);
    check("stream_cnt0", {28'd0, cnt0}, 32'd3);
    check("stream_cnt0_model", {28'd0, cnt0}, {28'd0, exp_cnt0});
    check("stream_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("stream_drained", q0.size(), 32'd0);

    // 3/4: fill stalled out1, then out0 must still flow
    out1_ready = 1'b0;
    send(8'hA1, 1'b1);
    send(8'hA2, 1'b1);
    sel = 1'b1;
    @(negedge clk);
    check("full1_in_ready", {31'd0, in_ready}, 32'd0);
    check("full1_head", {24'd0, out1_data}, 32'h0000_00A1);
    @(posedge clk); #1;
    send(8'h55, 1'b0);
    check("indep_out0_valid", {31'd0, out0_valid}, 32'd1);
    check("indep_out0_data", {24'd0, out0_data}, 32'h0000_0055);
    fork
      send(8'hA3, 1'b1);
      begin
        repeat (3) @(negedge clk);
        check("held_in_ready", {31'd0, in_ready}, 32'd0);
        check("held_out1_data", {24'd0, out1_data}, 32'h0000_00A1);
        @(posedge clk); #1;
        out1_ready = 1'b1;
      end
    join
    idle(4);
    check("bp_drained", q1.size(), 32'd0);
    check("bp_cnt1", {28'd0, cnt1}, 32'd3);
    check("bp_cnt1_model", {28'd0, cnt1}, {28'd0, exp_cnt1});
    check("bp_cnt0", {28'd0, cnt0}, 32'd4);

    // 5: both FIFOs full, asynchronous reset between edges
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b1);
    check("full_out0_valid", {31'd0, out0_valid}, 32'd1);
    check("full_out1_valid", {31'd0, out1_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("mid_rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("mid_rst_out1_data", {24'd0, out1_data}, 32'd0);
    check("mid_rst_cnt0", {28'd0, cnt0}, 32'd0);
    check("mid_rst_cnt1", {28'd0, cnt1}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    q0.delete();
    q1.delete();
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    @(posedge clk); #3;
    rst_n      = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle(3);
    check("after_rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("after_rst_out1_valid", {31'd0, out1_valid}, 32'd0);

    // 6: counter wrap with CNT_W=4
    for (int i = 0; i < 17; i++) send(8'(i + 8'h40), 1'b0);
    idle(3);
    check("wrap_cnt0", {28'd0, cnt0}, 32'd1);
    check("wrap_cnt0_model", {28'd0, cnt0}, {28'd0, exp_cnt0});
    check("wrap_drained", q0.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
